// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: turns frame ticks into counter increments and handles start, stop and expiry
module game_timer_ctrl #(
  parameter int unsigned TICKS_PER_INC = 60,
  parameter logic [7:0]  LIMIT         = 8'd99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] tout,
  output logic       inc,
  output logic       r,
  output logic       running,
  output logic       expired
);
  localparam int PW = TICKS_PER_INC > 1 ? $clog2(TICKS_PER_INC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_INC - 1);
  // One-hot states so that each status output is a flop bit, with no decode glitches
  typedef enum logic [3:0] {IDLE = 4'b0001, CLEAR = 4'b0010, RUN = 4'b0100, DONE = 4'b1000} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic inc_q, inc_d;
  logic at_limit, room, hold;
  assign at_limit = tout >= LIMIT && !inc_q;
  assign room = ({1'b0, tout} + 9'(inc_q)) < {1'b0, LIMIT};
  assign hold = !start && !stop && !at_limit;
  always_comb begin
    state_d = state_q;
    pre_d = '0;
    inc_d = 1'b0;
    case (state_q)
      IDLE:  state_d = start ? CLEAR : IDLE;
      CLEAR: state_d = RUN;
      RUN: begin
        state_d = start ? CLEAR : stop ? IDLE : at_limit ? DONE : RUN;
        pre_d = hold ? (frame ? (pre_q == PMAX ? '0 : pre_q + 1'b1) : pre_q) : '0;
        inc_d = hold && frame && pre_q == PMAX && room;
      end
      DONE:    state_d = start ? CLEAR : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q <= '0;
      inc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      inc_q <= inc_d;
    end
  assign inc = inc_q;
  assign r = state_q[1];
  assign running = state_q[2];
  assign expired = state_q[3];
endmodule
